pcm_frame_packer: RTL and testbench
===================================

Name: pcm_frame_packer

Overview:
- Downstream of the per-microphone CIC decimator bank.
- Captures one parallel frame of NCH 16-bit PCM samples (one per mic channel) on a sample strobe.
- Buffers frames in a 2-entry frame FIFO (ping-pong banks).
- Streams them out channel-serially over a valid/ready interface to the half-band/beamforming back end or the host link.

Parameters:
- NCH, 20, number of microphone channels per frame (≥2).
- W, 16, sample width in bits.
- CW, $clog2(NCH), channel index width.

Ports:
- CLKDIV  in  1  decimated-domain clock, all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- in_valid  in  1  one-cycle strobe: in_data holds a complete new frame.
- in_data  in  NCH*W  flattened frame; channel c at bits [c*W +: W].
- out_valid  out  1  out_data/out_chan/out_sof/out_eof valid.
- out_ready  in  1  consumer accepts the word when high with out_valid.
- out_data  out  W  sample word.
- out_chan  out  CW  channel index of out_data, 0..NCH-1.
- out_sof  out  1  high with channel 0 of a frame.
- out_eof  out  1  high with channel NCH-1 of a frame.
- overflow  out  1  sticky: a frame was dropped.
- clear_ovf  in  1  synchronous clear of overflow and drop_cnt.
- frame_cnt  out  16  accepted-frame counter, wraps 65535→0.
- drop_cnt  out  8  dropped-frame counter, saturates at 255.

Behaviour:
- Reset (async, RST=1): all outputs 0; bank write pointer, read pointer, frame count (0..2) and channel index cleared; bank contents don't-care. Reset mid-frame aborts readout; no out_eof is issued.
- Handshake: a word transfers on a rising edge with out_valid && out_ready. While out_valid && !out_ready, out_data, out_chan, out_sof and out_eof hold stable. out_valid never drops without a transfer.
- Capture (wr = in_valid && (count<2 || rd_last)), where rd_last = transfer of the out_eof word in the same cycle:
  - All NCH samples are written into bank[wr_ptr] in one cycle.
  - wr_ptr toggles and frame_cnt increments.
  - A bank freed in the same cycle is reusable, so a simultaneous last-read and capture never drops.
- Drop: in_valid && count==2 && !rd_last. Frame discarded; overflow set to 1; drop_cnt += 1 unless already 255. clear_ovf in the same cycle: clear wins, then this drop is counted (overflow=1, drop_cnt=1).
- count_next = count + wr − rd_last.
- FSM:
  - IDLE: out_valid=0, count==0. Go to SEND on the edge where wr=1. First word (chan 0, sof=1) is visible one cycle after the capturing edge.
  - SEND: out_valid=1; out_data = bank[rd_ptr][chan]. Each transfer increments chan. On transfer with chan==NCH-1:
    - chan←0 and rd_ptr toggles.
    - If count_next≥1, stay in SEND with no bubble: next word is chan 0 of the next frame, sof=1.
    - Otherwise go to IDLE.
- out_sof = (chan==0) && out_valid; out_eof = (chan==NCH-1) && out_valid.
- Minimum sustained rate: NCH cycles per frame with out_ready held high. in_valid spacing ≥NCH never overflows.
- No arithmetic on samples; bit-exact pass-through, sign-agnostic.

Test Plan:
- Reset then idle, out_ready=1, no in_valid for 50 cycles → out_valid=0, all counters 0, overflow=0.
- Single frame, channel c = 16'h0100+c (NCH=20), out_ready=1 → out_valid rises 1 cycle after strobe. 20 consecutive words 0x0100..0x0113, out_chan 0..19, sof on word 0, eof on word 19, then IDLE; frame_cnt=1.
- Backpressure: same frame, out_ready toggled 1,0,0,1 repeating → every word held stable while stalled; sequence and eof unchanged; total 20 transfers.
- Overflow: out_ready=0, three strobes frames A,B,C → A and B retained, C dropped. overflow=1, drop_cnt=1, frame_cnt=2. Release out_ready → 40 words A then B, no bubble at the frame boundary.
- Simultaneous free and capture: count=2, strobe coincides with transfer of out_eof → frame accepted, drop_cnt unchanged, count stays 2. Then clear_ovf pulse → overflow=0, drop_cnt=0.
- Async RST asserted mid-readout at chan=7 → outputs 0 immediately, no eof. After release, a new frame reads from chan 0 with sof=1.

Source files
------------

// File: rtl/pcm_frame_packer.sv
// pcm_frame_packer: captures a parallel frame of NCH PCM samples on a strobe,
// holds up to two frames in ping-pong banks and streams them out one channel
// per word over a valid/ready interface.
module pcm_frame_packer #(
  parameter int NCH = 20,
  parameter int W   = 16,
  parameter int CW  = $clog2(NCH)
) (
  input  logic             CLKDIV,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CW-1:0]    out_chan,
  output logic             out_sof,
  output logic             out_eof,
  output logic             overflow,
  input  logic             clear_ovf,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       drop_cnt
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [CW-1:0] LAST_CHAN = CW'(NCH - 1);

  state_t             state_r;
  logic [NCH*W-1:0]   bank_r [0:1];
  logic               wr_ptr_r;
  logic               rd_ptr_r;
  logic [1:0]         count_r;
  logic [CW-1:0]      chan_r;
  logic               out_valid_r;
  logic [W-1:0]       out_data_r;
  logic               out_sof_r;
  logic               out_eof_r;
  logic               overflow_r;
  logic [15:0]        frame_cnt_r;
  logic [7:0]         drop_cnt_r;

  logic               xfer_s;
  logic               rd_last_s;
  logic               wr_s;
  logic               drop_s;
  logic [1:0]         count_next_s;
  logic [CW-1:0]      nxt_chan_s;
  logic [W-1:0]       nxt_word_s;
  logic [NCH*W-1:0]   nxt_frame_s;

  // Select one channel word out of a flattened frame.
  function automatic logic [W-1:0] frame_word(input logic [NCH*W-1:0] frame,
                                              input logic [CW-1:0] idx);
    frame_word = frame[idx*W +: W];
  endfunction

  // Handshake, capture/drop decisions and next-word selection.
  always_comb begin
    xfer_s       = out_valid_r && out_ready;
    rd_last_s    = xfer_s && out_eof_r;
    wr_s         = in_valid && ((count_r < 2'd2) || rd_last_s);
    drop_s       = in_valid && !wr_s;
    count_next_s = count_r + {1'b0, wr_s} - {1'b0, rd_last_s};
    nxt_chan_s   = chan_r + CW'(1);
    nxt_word_s   = frame_word(bank_r[rd_ptr_r], nxt_chan_s);
    // With only one frame buffered, the follow-on frame is the one being
    // captured on this very edge, so it is taken straight from the input.
    if ((count_r == 2'd1) && wr_s) begin
      nxt_frame_s = in_data;
    end else begin
      nxt_frame_s = bank_r[~rd_ptr_r];
    end
  end

  // Frame bank storage; contents need no reset.
  always_ff @(posedge CLKDIV) begin
    if (wr_s) begin
      bank_r[wr_ptr_r] <= in_data;
    end
  end

  // Readout FSM with pointers, occupancy, counters and registered outputs.
  always_ff @(posedge CLKDIV or posedge RST) begin
    if (RST) begin
      state_r     <= IDLE;
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
      chan_r      <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_sof_r   <= 1'b0;
      out_eof_r   <= 1'b0;
      overflow_r  <= 1'b0;
      frame_cnt_r <= 16'd0;
      drop_cnt_r  <= 8'd0;
    end else begin
      count_r <= count_next_s;
      if (wr_s) begin
        wr_ptr_r    <= ~wr_ptr_r;
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      if (clear_ovf) begin
        overflow_r <= drop_s;
        drop_cnt_r <= drop_s ? 8'd1 : 8'd0;
      end else if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != 8'd255) begin
          drop_cnt_r <= drop_cnt_r + 8'd1;
        end
      end
      case (state_r)
        IDLE: begin
          if (wr_s) begin
            state_r     <= SEND;
            out_valid_r <= 1'b1;
            chan_r      <= {CW{1'b0}};
            out_data_r  <= in_data[W-1:0];
            out_sof_r   <= 1'b1;
            out_eof_r   <= 1'b0;
          end
        end
        SEND: begin
          if (xfer_s) begin
            if (out_eof_r) begin
              rd_ptr_r <= ~rd_ptr_r;
              chan_r   <= {CW{1'b0}};
              if (count_next_s != 2'd0) begin
                out_data_r <= nxt_frame_s[W-1:0];
                out_sof_r  <= 1'b1;
                out_eof_r  <= 1'b0;
              end else begin
                state_r     <= IDLE;
                out_valid_r <= 1'b0;
                out_sof_r   <= 1'b0;
                out_eof_r   <= 1'b0;
              end
            end else begin
              chan_r     <= nxt_chan_s;
              out_data_r <= nxt_word_s;
              out_sof_r  <= 1'b0;
              out_eof_r  <= (nxt_chan_s == LAST_CHAN);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          out_sof_r   <= 1'b0;
          out_eof_r   <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_chan  = chan_r;
  assign out_sof   = out_sof_r;
  assign out_eof   = out_eof_r;
  assign overflow  = overflow_r;
  assign frame_cnt = frame_cnt_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Self-checking bench for pcm_frame_packer: a queue-of-frames reference model
// is compared against the DUT on every falling edge, plus directed scenarios
// with literal expectations.
module tb_pcm_frame_packer;

  localparam int NCH = 20;
  localparam int W   = 16;
  localparam int CW  = $clog2(NCH);

  logic             CLKDIV = 1'b0;
  logic             RST = 1'b1;
  logic             in_valid = 1'b0;
  logic [NCH*W-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_data;
  logic [CW-1:0]    out_chan;
  logic             out_sof;
  logic             out_eof;
  logic             overflow;
  logic             clear_ovf = 1'b0;
  logic [15:0]      frame_cnt;
  logic [7:0]       drop_cnt;

  pcm_frame_packer #(.NCH(NCH), .W(W)) dut (
    .CLKDIV(CLKDIV), .RST(RST), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_sof(out_sof), .out_eof(out_eof),
    .overflow(overflow), .clear_ovf(clear_ovf), .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 CLKDIV = ~CLKDIV;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;

  // reference model state
  logic [NCH*W-1:0] mq[$];
  int               m_idx = 0;
  logic [15:0]      m_fc = 16'd0;
  logic [7:0]       m_dc = 8'd0;
  logic             m_ovf = 1'b0;

  // transfer log
  logic [W-1:0]  lg_data[$];
  logic [CW-1:0] lg_chan[$];
  logic          lg_sof[$];
  logic          lg_eof[$];
  int            lg_t[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NCH*W-1:0] mk_frame(input logic [15:0] base);
    logic [NCH*W-1:0] f;
    for (int c = 0; c < NCH; c++) f[c*W +: W] = base + 16'(c);
    return f;
  endfunction

  function automatic logic [NCH*W-1:0] rand_frame();
    logic [NCH*W-1:0] f;
    for (int c = 0; c < NCH; c++) f[c*W +: W] = 16'($urandom);
    return f;
  endfunction

  // Reference model: frames queue up to two deep, readout walks channels of the head.
  always @(posedge CLKDIV or posedge RST) begin
    if (RST) begin
      mq.delete();
      m_idx = 0; m_fc = 16'd0; m_dc = 8'd0; m_ovf = 1'b0;
    end else begin
      automatic bit xfer = (mq.size() > 0) && out_ready;
      automatic bit last = xfer && (m_idx == NCH - 1);
      automatic bit acc  = in_valid && ((mq.size() < 2) || last);
      automatic bit drp  = in_valid && !acc;
      cycle++;
      if (xfer) begin
        if (last) begin
          void'(mq.pop_front());
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (acc) begin
        mq.push_back(in_data);
        m_fc++;
      end
      if (clear_ovf) begin
        m_ovf = drp;
        m_dc  = drp ? 8'd1 : 8'd0;
      end else if (drp) begin
        m_ovf = 1'b1;
        if (m_dc != 8'd255) m_dc++;
      end
    end
  end

  // Compare DUT against the model every cycle, and log transfers.
  always @(negedge CLKDIV) begin
    automatic bit ev = (mq.size() > 0);
    automatic logic [NCH*W-1:0] fr;
    chk("out_valid", out_valid, ev);
    chk("frame_cnt", frame_cnt, m_fc);
    chk("drop_cnt", drop_cnt, m_dc);
    chk("overflow", overflow, m_ovf);
    if (ev) begin
      fr = mq[0];
      chk("out_data", out_data, fr[m_idx*W +: W]);
      chk("out_chan", out_chan, m_idx);
      chk("out_sof", out_sof, m_idx == 0);
      chk("out_eof", out_eof, m_idx == NCH - 1);
    end else begin
      chk("out_sof_idle", out_sof, 1'b0);
      chk("out_eof_idle", out_eof, 1'b0);
    end
    if (out_valid && out_ready) begin
      lg_data.push_back(out_data);
      lg_chan.push_back(out_chan);
      lg_sof.push_back(out_sof);
      lg_eof.push_back(out_eof);
      lg_t.push_back(cycle);
    end
  end

  task automatic cyc();
    @(posedge CLKDIV);
    #1;
    in_valid  = 1'b0;
    clear_ovf = 1'b0;
  endtask

  task automatic strobe(input logic [NCH*W-1:0] f);
    in_data  = f;
    in_valid = 1'b1;
    cyc();
  endtask

  task automatic do_reset();
    @(posedge CLKDIV);
    #1;
    RST = 1'b1;
    in_valid = 1'b0; clear_ovf = 1'b0;
    cyc();
    RST = 1'b0;
  endtask

  task automatic clr_log();
    lg_data.delete(); lg_chan.delete(); lg_sof.delete(); lg_eof.delete(); lg_t.delete();
  endtask

  task automatic rand_phase(input int n, input int p_in, input int p_rdy, input int p_clr);
    for (int i = 0; i < n; i++) begin
      in_data   = rand_frame();
      in_valid  = ($urandom_range(99) < p_in);
      out_ready = ($urandom_range(99) < p_rdy);
      clear_ovf = ($urandom_range(99) < p_clr);
      @(posedge CLKDIV);
      #1;
    end
    in_valid = 1'b0; clear_ovf = 1'b0;
  endtask

  initial begin
    logic [NCH*W-1:0] fa, fb, fc;
    bit found;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    fa = mk_frame(16'hA000);
    fb = mk_frame(16'hB000);
    fc = mk_frame(16'hC000);

    // 1: reset then idle
    repeat (2) @(posedge CLKDIV);
    #1 RST = 1'b0;
    out_ready = 1'b1;
    repeat (50) cyc();
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_fcnt", frame_cnt, 16'd0);
    chk("idle_dcnt", drop_cnt, 8'd0);
    chk("idle_ovf", overflow, 1'b0);

    // 2: single frame straight through
    do_reset();
    clr_log();
    out_ready = 1'b1;
    strobe(mk_frame(16'h0100));
    chk("first_valid", out_valid, 1'b1);
    chk("first_sof", out_sof, 1'b1);
    chk("first_data", out_data, 16'h0100);
    repeat (25) cyc();
    chk("single_len", lg_data.size(), 20);
    for (int i = 0; i < lg_data.size() && i < 20; i++) begin
      chk("single_data", lg_data[i], 16'h0100 + 16'(i));
      chk("single_chan", lg_chan[i], i);
      chk("single_sof", lg_sof[i], i == 0);
      chk("single_eof", lg_eof[i], i == 19);
    end
    chk("single_idle", out_valid, 1'b0);
    chk("single_fcnt", frame_cnt, 16'd1);

    // 3: backpressure 1,0,0,1
    do_reset();
    clr_log();
    in_data = mk_frame(16'h0100);
    in_valid = 1'b1;
    for (int k = 0; k < 90; k++) begin
      out_ready = pat[k % 4];
      cyc();
    end
    chk("bp_len", lg_data.size(), 20);
    for (int i = 0; i < lg_data.size() && i < 20; i++) begin
      chk("bp_data", lg_data[i], 16'h0100 + 16'(i));
      chk("bp_eof", lg_eof[i], i == 19);
    end

    // 4: overflow with three back-to-back strobes while stalled
    do_reset();
    out_ready = 1'b0;
    strobe(fa); strobe(fb); strobe(fc);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_dcnt", drop_cnt, 8'd1);
    chk("ovf_fcnt", frame_cnt, 16'd2);
    clr_log();
    out_ready = 1'b1;
    repeat (45) cyc();
    chk("ovf_len", lg_data.size(), 40);
    if (lg_data.size() == 40) begin
      for (int i = 0; i < 40; i++)
        chk("ovf_data", lg_data[i], (i < 20 ? 16'hA000 : 16'hB000) + 16'(i % 20));
      chk("ovf_nobubble", lg_t[39] - lg_t[0], 39);
    end
    clear_ovf = 1'b1;
    cyc();
    chk("clr_ovf", overflow, 1'b0);
    chk("clr_dcnt", drop_cnt, 8'd0);

    // 5: capture coinciding with last-word transfer while full
    do_reset();
    out_ready = 1'b0;
    strobe(fa); strobe(fb);
    clr_log();
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (out_valid && out_eof) found = 1'b1;
      else cyc();
    end
    chk("sim_wait_eof", found, 1'b1);
    strobe(fc);
    chk("sim_dcnt", drop_cnt, 8'd0);
    chk("sim_ovf", overflow, 1'b0);
    chk("sim_fcnt", frame_cnt, 16'd3);
    repeat (50) cyc();
    chk("sim_len", lg_data.size(), 60);
    if (lg_data.size() == 60) begin
      chk("sim_c0", lg_data[40], 16'hC000);
      chk("sim_c19", lg_data[59], 16'hC013);
      chk("sim_b0", lg_data[20], 16'hB000);
    end

    // 6: async reset mid-readout
    do_reset();
    out_ready = 1'b1;
    strobe(fa);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (out_valid && out_chan == 5'd7) found = 1'b1;
      else cyc();
    end
    chk("rst_wait_chan7", found, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_chan", out_chan, 5'd0);
    chk("rst_eof", out_eof, 1'b0);
    chk("rst_fcnt", frame_cnt, 16'd0);
    @(posedge CLKDIV);
    #1 RST = 1'b0;
    strobe(fb);
    chk("rst_new_chan", out_chan, 5'd0);
    chk("rst_new_sof", out_sof, 1'b1);
    chk("rst_new_data", out_data, 16'hB000);
    repeat (25) cyc();

    // 7: drop counter saturation
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = rand_frame();
      @(posedge CLKDIV);
      #1;
    end
    in_valid = 1'b0;
    chk("sat_dcnt", drop_cnt, 8'd255);
    chk("sat_fcnt", frame_cnt, 16'd2);
    out_ready = 1'b1;
    repeat (45) cyc();

    // 8: strobes spaced NCH apart never overflow
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = rand_frame();
      in_valid = 1'b1;
      cyc();
      repeat (NCH - 1) cyc();
    end
    chk("spaced_ovf", overflow, 1'b0);
    chk("spaced_fcnt", frame_cnt, 16'd10);

    // 9: randomized traffic against the model
    do_reset();
    rand_phase(1500, 10, 80, 2);
    rand_phase(1500, 40, 50, 3);
    rand_phase(1000, 5, 95, 1);
    out_ready = 1'b1;
    repeat (60) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
